uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO.
// Frame format: one start bit (0), WIDTH data bits sent LSB first, one stop bit (1).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle high; leaves for ST_REQ when tx_enable is high
// ST_REQ   | single-cycle pop request to the FIFO
// ST_WAIT  | capture the byte if fifo_valid is high, else back to IDLE
// ST_START | start bit (low) for CLKS_PER_BIT cycles
// ST_DATA  | WIDTH data bits, LSB first
// ST_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_enable,
  output logic             fifo_read_enable,
  input  logic [WIDTH-1:0] fifo_read_data,
  input  logic             fifo_valid,
  output logic             tx,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  // Holds off the first pop until one edge has passed after reset release.
  logic             armed_q;

  // Next-state, bit-cycle counter, bit index and shift register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_enable && armed_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifo_valid) begin
          shift_d = fifo_read_data;
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d   = 1'b1;
    rd_d   = (state_d == ST_REQ);
    busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
  end

  // State and output registers; reset drops any in-flight byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      armed_q <= 1'b1;
    end
  end

  assign tx               = tx_q;
  assign busy             = busy_q;
  assign fifo_read_enable = rd_q;

endmodule
